// File: rtl/aes_ctrl_pkg.sv
// Shared types and constants for the AES round sequencer: FSM states,
// key-mode encodings and the mode-to-round-count mapping.
package aes_ctrl_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_POP   = 3'd1,
      S_WAIT  = 3'd2,
      S_INIT  = 3'd3,
      S_ROUND = 3'd4,
      S_DONE  = 3'd5,
      S_ERR   = 3'd6
   } state_e;

   localparam logic [1:0] MODE_128  = 2'd0;
   localparam logic [1:0] MODE_192  = 2'd1;
   localparam logic [1:0] MODE_256  = 2'd2;
   localparam logic [1:0] MODE_RSVD = 2'd3;

   localparam logic [3:0] NR_128 = 4'd10;
   localparam logic [3:0] NR_192 = 4'd12;
   localparam logic [3:0] NR_256 = 4'd14;

   // The reserved mode maps to zero rounds; it is never used to run rounds.
   function automatic logic [3:0] mode_to_nr(input logic [1:0] mode);
      logic [3:0] nr;
      case (mode)
         MODE_128: nr = NR_128;
         MODE_192: nr = NR_192;
         MODE_256: nr = NR_256;
         default:  nr = 4'd0;
      endcase
      return nr;
   endfunction

endpackage

// File: rtl/mode_occ_tracker.sv
// Mirror of the key-mode FIFO occupancy, since the FIFO itself only reports full.
// Saturates at FIFO_SZ and raises a sticky overflow flag on a push into a full FIFO.
module mode_occ_tracker #(
   parameter int FIFO_SZ = 5,
   parameter int OCC_W   = $clog2(FIFO_SZ + 1)
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             push,
   input  logic             pop,
   output logic [OCC_W-1:0] occ,
   output logic             ovf
);

   logic [OCC_W-1:0] occ_q, occ_d;
   logic             ovf_q, ovf_d;

   // A full FIFO drops its oldest entry on push, so the count stays pinned.
   always_comb begin
      occ_d = occ_q;
      ovf_d = ovf_q;
      case ({push, pop})
         2'b10: begin
            if (occ_q == OCC_W'(FIFO_SZ)) begin
               ovf_d = 1'b1;
            end else begin
               occ_d = occ_q + OCC_W'(1);
            end
         end
         2'b01: begin
            if (occ_q != '0) begin
               occ_d = occ_q - OCC_W'(1);
            end
         end
         default: begin
            occ_d = occ_q;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         occ_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         occ_q <= occ_d;
         ovf_q <= ovf_d;
      end
   end

   assign occ = occ_q;
   assign ovf = ovf_q;

endmodule

// File: rtl/aes_round_ctrl.sv
// AES round sequencer: pops one key mode per block, then steps the round
// datapath through init, N rounds and a done pulse, with hold-based stalling.
module aes_round_ctrl
   import aes_ctrl_pkg::*;
#(
   parameter int FIFO_SZ = 5,
   parameter int IDX_W   = 4
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             mode_push,
   output logic             mode_pop,
   input  logic [1:0]       mode_in,
   input  logic             blk_valid,
   output logic             blk_ready,
   input  logic             hold,
   output logic             round_en,
   output logic             init_round,
   output logic             last_round,
   output logic [IDX_W-1:0] round_idx,
   output logic [1:0]       key_mode,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic             ovf
);

   localparam int OCC_W = $clog2(FIFO_SZ + 1);

   state_e           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [IDX_W-1:0] nr_q, nr_d;
   logic [1:0]       key_mode_q, key_mode_d;
   logic [OCC_W-1:0] occ;

   mode_occ_tracker #(
      .FIFO_SZ (FIFO_SZ),
      .OCC_W   (OCC_W)
   ) u_occ (
      .clk    (clk),
      .resetn (resetn),
      .push   (mode_push),
      .pop    (mode_pop),
      .occ    (occ),
      .ovf    (ovf)
   );

   // All strobes decode from the registered state, so reset clears them at once.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      nr_d       = nr_q;
      key_mode_d = key_mode_q;
      mode_pop   = 1'b0;
      blk_ready  = 1'b0;
      init_round = 1'b0;
      round_en   = 1'b0;
      last_round = 1'b0;
      done       = 1'b0;
      err        = 1'b0;
      busy       = (state_q != S_IDLE);

      case (state_q)
         S_IDLE: begin
            if ((occ != '0) && blk_valid) begin
               state_d = S_POP;
            end
         end
         S_POP: begin
            mode_pop = 1'b1;
            state_d  = S_WAIT;
         end
         S_WAIT: begin
            blk_ready  = 1'b1;
            key_mode_d = mode_in;
            nr_d       = IDX_W'(mode_to_nr(mode_in));
            idx_d      = '0;
            state_d    = (mode_in == MODE_RSVD) ? S_ERR : S_INIT;
         end
         S_INIT: begin
            init_round = 1'b1;
            idx_d      = IDX_W'(1);
            state_d    = S_ROUND;
         end
         S_ROUND: begin
            // hold freezes both the index and the state for that cycle
            if (!hold) begin
               round_en = 1'b1;
               if (idx_q == nr_q) begin
                  last_round = 1'b1;
                  idx_d      = '0;
                  state_d    = S_DONE;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         S_ERR: begin
            err     = 1'b1;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q    <= S_IDLE;
         idx_q      <= '0;
         nr_q       <= '0;
         key_mode_q <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         nr_q       <= nr_d;
         key_mode_q <= key_mode_d;
      end
   end

   assign round_idx = idx_q;
   assign key_mode  = key_mode_q;

   a_pop_nonempty: assert property (@(posedge clk) disable iff (!resetn)
      mode_pop |-> (occ != '0));

   a_idx_in_range: assert property (@(posedge clk) disable iff (!resetn)
      (state_q == S_ROUND) |-> ((idx_q >= IDX_W'(1)) && (idx_q <= nr_q)));

   a_single_strobe: assert property (@(posedge clk) disable iff (!resetn)
      $onehot0({mode_pop, blk_ready, init_round, round_en, done, err}));

endmodule

// File: doc/aes_round_ctrl.md
Name: aes_round_ctrl

Overview:
Round sequencer that sits directly downstream of the key-mode FIFO in the AES core. It pops one 2-bit key mode per data block and derives the round count from it: 10 rounds for AES-128, 12 for AES-192, 14 for AES-256. It then drives the round datapath one round per cycle, with init, last-round and stall control. It also keeps a mirrored occupancy count of the mode FIFO, because the FIFO exposes only a full flag and no empty flag.

Parameters:
FIFO_SZ, 5, depth of the upstream mode FIFO; ceiling for the occupancy mirror
IDX_W, 4, width of round_idx; must hold 14

Ports:
clk  in  1  clock, rising edge
resetn  in  1  reset, synchronous, active-low
mode_push  in  1  same strobe that drives the FIFO data-in control; counts one entry per cycle high
mode_pop  out  1  drives the FIFO data-out control; one-cycle registered pulse
mode_in  in  2  FIFO data output; valid the cycle after mode_pop is high
blk_valid  in  1  datapath holds a block to process; held high until accepted
blk_ready  out  1  block accepted in the cycle where blk_valid && blk_ready
hold  in  1  stall; freezes round progress
round_en  out  1  datapath executes round round_idx this cycle
init_round  out  1  initial AddRoundKey-only cycle
last_round  out  1  final round, with MixColumns skipped
round_idx  out  IDX_W  current round number, 0..N
key_mode  out  2  latched mode of the block in flight
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when the block is finished
err  out  1  one-cycle pulse when mode 3 (reserved) is popped
ovf  out  1  sticky; a push arrived while the occupancy mirror was at FIFO_SZ

Behaviour:
- Reset: synchronous and active-low. At the first rising edge with resetn=0, every output goes to 0, the state goes to IDLE and the occupancy mirror clears. This applies mid-operation too, with no completion pulse.
- Mode decode: 0 -> N=10, 1 -> N=12, 2 -> N=14, 3 -> reserved (error).
- Occupancy mirror (occ, width clog2(FIFO_SZ+1)):
  - +1 on mode_push; -1 on mode_pop; unchanged when both occur in the same cycle.
  - A push at occ==FIFO_SZ leaves occ at FIFO_SZ and sets ovf. The FIFO drops its oldest entry in that case.
  - A pop is only issued when occ>0, so the mirror never underflows.
- FSM states: IDLE, POP, WAIT, INIT, ROUND, DONE, ERR.
- IDLE: go to POP when occ!=0 && blk_valid; otherwise stay.
- POP: mode_pop=1 for exactly one cycle, then WAIT.
- WAIT:
  - blk_ready=1; key_mode and N latched from mode_in at the clock edge.
  - Next state is ERR if mode_in==3, else INIT.
- INIT: init_round=1, round_idx=0; then go to ROUND with round_idx=1.
- ROUND:
  - When hold=0: round_en=1, and round_idx increments each cycle.
  - When hold=1: round_en=0, and round_idx/state are frozen.
  - last_round=1 while round_idx==N (gated by the same hold rule as round_en).
  - Leave for DONE after the round_idx==N cycle completes with hold=0.
- DONE: done=1 for one cycle, then IDLE. key_mode remains valid until the next WAIT.
- ERR: err=1 for one cycle. The block was already accepted in WAIT and is dropped. Then IDLE; no rounds are issued.
- hold is ignored outside ROUND.
- Latency, with cycle 0 = IDLE cycle where the start condition holds:
  - POP@1, WAIT@2, INIT@3, ROUND@4..3+N, done@4+N.
  - No-hold latency: mode0 -> 14, mode1 -> 16, mode2 -> 18.
  - Back-to-back blocks insert one IDLE cycle between done and the next POP.
- A mode_push during any state only updates occ; it never aborts a block.

Decomposition:
- Package aes_ctrl_pkg:
  - state enum.
  - Mode encodings MODE_128/192/256/RSVD.
  - Constants NR_128=10, NR_192=12, NR_256=14.
  - Function mode_to_nr().
- Sub-module mode_occ_tracker: occupancy counter, saturation and ovf. Ports: clk, resetn, push, pop, occ, ovf.
- FSM and round counter stay in aes_round_ctrl.

Test Plan:
1. Reset then idle: push mode 2 once, no blk_valid -> occ=1, mode_pop never asserts, busy=0.
2. Push mode 0, raise blk_valid at cycle 0 -> mode_pop@1, blk_ready@2, init_round@3, round_idx 1..10 @4..13, last_round@13, done@14, key_mode=0.
3. Mode 2, with hold=1 for 3 cycles at round_idx=5 -> round_en=0 for 3 cycles, round_idx stays 5, done at cycle 21.
4. Push mode 3 then mode 1 with blk_valid held high:
   - err@3, no round_en.
   - Second block: POP@5, 12 rounds, done@20.
5. Six pushes with no pops (FIFO_SZ=5) -> occ=5, ovf=1 and remains 1 until reset. A simultaneous push+pop in a later cycle leaves occ unchanged.
6. Assert resetn=0 during ROUND at round_idx=7 -> all outputs 0 next edge, state IDLE, occ=0, no done or err pulse.
